clk_div_ctrl: RTL and testbench



---
 rtl/clk_div_ctrl_if.sv | 33 +++
 rtl/clk_div_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// Bundle between the system side (requesters plus divider feedback) and the
// divider reconfiguration controller.
interface clk_div_ctrl_if #(
  parameter int RATIO_W = 3
);
  // requester A
  logic               i_req_a;
  logic [RATIO_W-1:0] i_ratio_a;
  logic               o_ack_a;
  // requester B
  logic               i_req_b;
  logic [RATIO_W-1:0] i_ratio_b;
  logic               o_ack_b;
  // divider side
  logic               i_div_clk;
  logic               o_clk_en;
  logic [RATIO_W-1:0] o_div_ratio;
  // status
  logic               o_err;
  logic               o_busy;

  // Controller view
  modport slave (
    input  i_req_a, i_ratio_a, i_req_b, i_ratio_b, i_div_clk,
    output o_ack_a, o_ack_b, o_clk_en, o_div_ratio, o_err, o_busy
  );

  // Requester / system view
  modport master (
    output i_req_a, i_ratio_a, i_req_b, i_ratio_b, i_div_clk,
    input  o_ack_a, o_ack_b, o_clk_en, o_div_ratio, o_err, o_busy
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Reconfiguration controller for an integer clock divider. Two requesters
// ask for a new ratio; requests are arbitrated round-robin, validated, and
// applied with a glitch-safe sequence: wait for the divided clock to be low,
// gate the enable, load the ratio while gated, then re-enable.
module clk_div_ctrl #(
  parameter int RATIO_W   = 3,
  parameter int DEF_RATIO = 2,
  parameter int HOLD_CYC  = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic          i_ref_clk,
  input  logic          i_rst,
  clk_div_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_WAIT_LOW = 3'd2,
    ST_GATE     = 3'd3,
    ST_LOAD     = 3'd4,
    ST_ENABLE   = 3'd5
  } state_t;

  // Wait counter runs 0..TIMEOUT-1, hold counter runs 0..HOLD_CYC-1.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [RATIO_W-1:0] RATIO_DEF  = RATIO_W'(DEF_RATIO);
  localparam logic [RATIO_W-1:0] RATIO_BYP  = RATIO_W'(1);
  localparam logic [RATIO_W-1:0] RATIO_ZERO = '0;

  // State and working registers
  state_t             r_state;
  logic               r_grant_b;   // 1: current transaction belongs to B
  logic               r_last_b;    // 1: B was granted most recently
  logic [RATIO_W-1:0] r_ratio;     // latched requested ratio
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;

  // Registered outputs
  logic               r_clk_en;
  logic [RATIO_W-1:0] r_div_ratio;
  logic               r_ack_a;
  logic               r_ack_b;
  logic               r_err;
  logic               r_busy;

  // Next-state values
  state_t             w_state_next;
  logic               w_grant_b_next;
  logic               w_last_b_next;
  logic [RATIO_W-1:0] w_ratio_next;
  logic [WAIT_W-1:0]  w_wait_cnt_next;
  logic [HOLD_W-1:0]  w_hold_cnt_next;
  logic               w_clk_en_next;
  logic [RATIO_W-1:0] w_div_ratio_next;
  logic               w_ack_a_next;
  logic               w_ack_b_next;
  logic               w_err_next;
  logic               w_busy_next;

  // Arbitration helpers
  logic               w_req_a;
  logic               w_req_b;
  logic               w_any_req;
  logic               w_pick_b;
  logic [RATIO_W-1:0] w_sel_ratio;
  logic               w_low_seen;

  // A requester whose ack is on the bus this cycle has not yet had a chance
  // to drop its level request, so it is masked to avoid a spurious re-grant.
  assign w_req_a   = bus.i_req_a & ~r_ack_a;
  assign w_req_b   = bus.i_req_b & ~r_ack_b;
  assign w_any_req = w_req_a | w_req_b;

  // B wins when it is alone, or on a tie when A was granted last.
  assign w_pick_b    = w_req_b & (~w_req_a | ~r_last_b);
  assign w_sel_ratio = w_pick_b ? bus.i_ratio_b : bus.i_ratio_a;

  // Safe to gate: divided clock low, bypass ratio (no divided phase), or
  // the wait budget is used up.
  assign w_low_seen = ~bus.i_div_clk | (r_div_ratio == RATIO_BYP) |
                      (r_wait_cnt == WAIT_LAST);

  // Next-state and output decode
  always_comb begin
    w_state_next     = r_state;
    w_grant_b_next   = r_grant_b;
    w_last_b_next    = r_last_b;
    w_ratio_next     = r_ratio;
    w_wait_cnt_next  = r_wait_cnt;
    w_hold_cnt_next  = r_hold_cnt;
    w_clk_en_next    = r_clk_en;
    w_div_ratio_next = r_div_ratio;
    w_ack_a_next     = 1'b0;
    w_ack_b_next     = 1'b0;
    w_err_next       = 1'b0;
    w_busy_next      = r_busy;

    case (r_state)
      ST_IDLE: begin
        w_busy_next = w_any_req;
        if (w_any_req) begin
          w_grant_b_next = w_pick_b;
          w_last_b_next  = w_pick_b;
          w_ratio_next   = w_sel_ratio;
          w_state_next   = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (r_ratio == RATIO_ZERO) begin
          // Rejected: acknowledge with error, divider untouched.
          w_ack_a_next = ~r_grant_b;
          w_ack_b_next = r_grant_b;
          w_err_next   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_ratio == r_div_ratio) begin
          // Nothing to change: acknowledge without gating.
          w_ack_a_next = ~r_grant_b;
          w_ack_b_next = r_grant_b;
          w_state_next = ST_IDLE;
        end else begin
          w_wait_cnt_next = '0;
          w_state_next    = ST_WAIT_LOW;
        end
      end

      ST_WAIT_LOW: begin
        if (w_low_seen) begin
          w_clk_en_next   = 1'b0;
          w_hold_cnt_next = '0;
          w_state_next    = ST_GATE;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end

      ST_GATE: begin
        if (r_hold_cnt == HOLD_LAST) begin
          // Ratio changes only while the enable is held low.
          w_div_ratio_next = r_ratio;
          w_state_next     = ST_LOAD;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end

      ST_LOAD: begin
        // Re-enable and acknowledge land in the same cycle.
        w_clk_en_next = 1'b1;
        w_ack_a_next  = ~r_grant_b;
        w_ack_b_next  = r_grant_b;
        w_state_next  = ST_ENABLE;
      end

      ST_ENABLE: begin
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next  = ST_IDLE;
        w_clk_en_next = 1'b1;
        w_busy_next   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any sequence in flight.
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_grant_b   <= 1'b0;
      r_last_b    <= 1'b1;
      r_ratio     <= RATIO_DEF;
      r_wait_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_clk_en    <= 1'b1;
      r_div_ratio <= RATIO_DEF;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_grant_b   <= w_grant_b_next;
      r_last_b    <= w_last_b_next;
      r_ratio     <= w_ratio_next;
      r_wait_cnt  <= w_wait_cnt_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_clk_en    <= w_clk_en_next;
      r_div_ratio <= w_div_ratio_next;
      r_ack_a     <= w_ack_a_next;
      r_ack_b     <= w_ack_b_next;
      r_err       <= w_err_next;
      r_busy      <= w_busy_next;
    end
  end

  assign bus.o_clk_en    = r_clk_en;
  assign bus.o_div_ratio = r_div_ratio;
  assign bus.o_ack_a     = r_ack_a;
  assign bus.o_ack_b     = r_ack_b;
  assign bus.o_err       = r_err;
  assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed steps plus random requests,
// each checked cycle by cycle against a timeline derived from the rules.
module tb_clk_div_ctrl;
  localparam int RATIO_W   = 3;
  localparam int DEF_RATIO = 2;
  localparam int HOLD_CYC  = 2;
  localparam int TIMEOUT   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;
  int txn_no   = 0;

  // Reference state: current divider ratio and who was granted last.
  logic [2:0] m_ratio  = 3'(DEF_RATIO);
  bit         m_last_b = 1'b1;

  clk_div_ctrl_if #(.RATIO_W(RATIO_W)) bus();

  clk_div_ctrl #(
    .RATIO_W  (RATIO_W),
    .DEF_RATIO(DEF_RATIO),
    .HOLD_CYC (HOLD_CYC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_ref_clk(clk),
    .i_rst    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // {clk_en, div_ratio, ack_a, ack_b, err, busy}
  function automatic logic [7:0] obs_vec();
    return {bus.o_clk_en, bus.o_div_ratio, bus.o_ack_a, bus.o_ack_b,
            bus.o_err, bus.o_busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] other_ratio(input logic [2:0] want);
    if (want == m_ratio) return (want == 3'd7) ? 3'd6 : 3'(want + 3'd1);
    return want;
  endfunction

  // One request from a single requester, entered at a negedge with the DUT
  // idle. mode: 0 random div_clk, 1 held high, 2 held low, 3 ratio-3 square.
  task automatic run_txn(input bit who_b, input logic [2:0] ratio,
                         input int mode);
    logic [2:0] cur;
    bit         div_pat [64];
    bit         gated, rej, found;
    int         k, ack_i, ph;
    logic [7:0] exp_v;
    cur = m_ratio;
    ph  = $urandom_range(0, 2);
    for (int j = 0; j < 64; j++) begin
      case (mode)
        0:       div_pat[j] = 1'($urandom_range(0, 1));
        1:       div_pat[j] = 1'b1;
        2:       div_pat[j] = 1'b0;
        default: div_pat[j] = ((j + ph) % 3) != 0;
      endcase
    end
    // Cycle 0 presents the request, cycle 1 is the check, waiting starts at 2.
    rej   = (ratio == 3'd0);
    gated = !rej && (ratio != cur);
    k     = 0;
    if (!gated) begin
      ack_i = 2;
    end else begin
      k = 2 + TIMEOUT - 1;
      if (cur == 3'd1) begin
        k = 2;
      end else begin
        found = 1'b0;
        for (int j = 2; j < 2 + TIMEOUT; j++) begin
          if (!found && !div_pat[j]) begin
            found = 1'b1;
            k = j;
          end
        end
      end
      ack_i = k + HOLD_CYC + 2;
    end
    for (int i = 0; i <= ack_i + 1; i++) begin
      exp_v[7]   = !(gated && i >= k + 1 && i <= k + HOLD_CYC + 1);
      exp_v[6:4] = (gated && i >= k + HOLD_CYC + 1) ? ratio : cur;
      exp_v[3]   = (i == ack_i) && !who_b;
      exp_v[2]   = (i == ack_i) && who_b;
      exp_v[1]   = (i == ack_i) && rej;
      exp_v[0]   = (i >= 1) && (i <= ack_i);
      check($sformatf("txn%0d_cyc%0d", txn_no, i), obs_vec(), exp_v);
      bus.i_req_a   = !who_b && (i < ack_i);
      bus.i_req_b   = who_b && (i < ack_i);
      bus.i_ratio_a = ratio;
      bus.i_ratio_b = ratio;
      bus.i_div_clk = div_pat[i];
      @(negedge clk);
    end
    m_last_b = who_b;
    if (gated) m_ratio = ratio;
    $display("txn %0d: req=%s ratio=%0d mode=%0d ack_cycle=%0d gated=%0d err=%0d ratio_now=%0d",
             txn_no, who_b ? "B" : "A", ratio, mode, ack_i, gated, rej, m_ratio);
    txn_no++;
  endtask

  // Both requesters raise a request in the same cycle.
  task automatic run_tie(input logic [2:0] ra, input logic [2:0] rb);
    bit         exp_first_b, got_a, got_b, first_b, have_first, err_a, err_b;
    logic [2:0] exp_ratio;
    int         cnt;
    got_a = 0; got_b = 0; first_b = 0; have_first = 0; err_a = 0; err_b = 0;
    cnt = 0;
    exp_first_b = !m_last_b;
    exp_ratio   = m_ratio;
    if (exp_first_b) begin
      if (rb != 3'd0) exp_ratio = rb;
      if (ra != 3'd0) exp_ratio = ra;
    end else begin
      if (ra != 3'd0) exp_ratio = ra;
      if (rb != 3'd0) exp_ratio = rb;
    end
    while (!(got_a && got_b) && cnt < 80) begin
      check($sformatf("tie%0d_onehot_ack", txn_no),
            32'(bus.o_ack_a & bus.o_ack_b), 32'd0);
      if (bus.o_ack_a && !got_a) begin
        got_a = 1; err_a = bus.o_err;
        if (!have_first) begin have_first = 1; first_b = 0; end
      end
      if (bus.o_ack_b && !got_b) begin
        got_b = 1; err_b = bus.o_err;
        if (!have_first) begin have_first = 1; first_b = 1; end
      end
      bus.i_req_a   = !got_a;
      bus.i_req_b   = !got_b;
      bus.i_ratio_a = ra;
      bus.i_ratio_b = rb;
      bus.i_div_clk = 1'($urandom_range(0, 1));
      @(negedge clk);
      cnt++;
    end
    check($sformatf("tie%0d_both_acked", txn_no), {30'd0, got_a, got_b}, 32'd3);
    check($sformatf("tie%0d_order", txn_no), 32'(first_b), 32'(exp_first_b));
    check($sformatf("tie%0d_err_a", txn_no), 32'(err_a), 32'(ra == 3'd0));
    check($sformatf("tie%0d_err_b", txn_no), 32'(err_b), 32'(rb == 3'd0));
    check($sformatf("tie%0d_final", txn_no),
          {28'd0, bus.o_div_ratio, bus.o_busy}, {28'd0, exp_ratio, 1'b0});
    m_ratio  = exp_ratio;
    m_last_b = !exp_first_b;
    $display("txn %0d: tie ratio_a=%0d ratio_b=%0d first=%s ratio_now=%0d",
             txn_no, ra, rb, exp_first_b ? "B" : "A", m_ratio);
    txn_no++;
  endtask

  initial begin
    logic [7:0] idle_def;
    logic [2:0] r;
    idle_def = {1'b1, 3'(DEF_RATIO), 4'b0000};

    bus.i_req_a   = 1'b0;
    bus.i_req_b   = 1'b0;
    bus.i_ratio_a = 3'd0;
    bus.i_ratio_b = 3'd0;
    bus.i_div_clk = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", obs_vec(), idle_def);
    rst = 1'b0;

    // Basic change with divided clock already low
    run_txn(1'b0, 3'd4, 2);

    // Round-robin ties, with a single A grant between them
    run_tie(3'd3, 3'd4);
    run_txn(1'b0, other_ratio(3'd5), 2);
    run_tie(3'd6, 3'd3);

    // Rejected ratio, then a no-change request
    run_txn(1'b1, 3'd0, 0);
    run_txn(1'b0, m_ratio, 0);

    // Forced switch on timeout, then phase-aligned switch on a square div_clk
    run_txn(1'b1, other_ratio(3'd5), 1);
    run_txn(1'b0, other_ratio(3'd3), 3);

    // Bypass ratio in, then out of bypass with div_clk held high
    run_txn(1'b0, other_ratio(3'd1), 1);
    run_txn(1'b1, other_ratio(3'd6), 1);

    // Back-to-back from the same requester
    run_txn(1'b1, other_ratio(3'd2), 0);
    run_txn(1'b1, other_ratio(3'd7), 0);

    // Random requests
    for (int n = 0; n < 30; n++) begin
      r = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) r = m_ratio;
      run_txn(1'($urandom_range(0, 1)), r, int'($urandom_range(0, 3)));
    end
    run_tie(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    // Reset in the middle of the gate window, request held across it
    r = (m_ratio == 3'd5) ? 3'd6 : 3'd5;
    bus.i_req_a   = 1'b1;
    bus.i_ratio_a = r;
    bus.i_req_b   = 1'b0;
    bus.i_div_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_gate_en_low", 32'(bus.o_clk_en), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", obs_vec(), idle_def);
    repeat (2) begin
      @(negedge clk);
      check("rst_held_no_ack", obs_vec(), idle_def);
    end
    m_ratio  = 3'(DEF_RATIO);
    m_last_b = 1'b1;
    rst = 1'b0;
    run_txn(1'b0, r, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
